fpu_apu_arbiter: RTL and testbench

- Shares one fpnew_wrapper FPU instance between NB_CORES APU requesters.
- Arbitration is round-robin with an outstanding-operation credit limit.
- Each issued request is tagged with the requester index in the FPU ID field, and FPU responses are routed back to the originating core.
- Sits between the cores' APU master ports and the FPU slave port inside the FPU interconnect.

---
 rtl/fpu_apu_arbiter.sv | 155 +++++++++++++++
 tb/tb_fpu_apu_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_apu_arbiter.sv
// Round-robin arbiter sharing one FPU among NB_CORES APU requesters, with an outstanding-op credit limit.
// Optional issue counter on perf_grant_cnt_o, enabled by defining FPU_ARB_PERF_CNT_EN.
module fpu_apu_arbiter #(
    parameter int unsigned NB_CORES        = 4,
    parameter int unsigned NB_ARGS         = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned OPCODE_WIDTH    = 6,
    parameter int unsigned FLAGS_IN_WIDTH  = 15,
    parameter int unsigned FLAGS_OUT_WIDTH = 5,
    parameter int unsigned CORE_TAG_WIDTH  = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned FPU_ID_WIDTH   = CORE_TAG_WIDTH + $clog2(NB_CORES)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NB_CORES-1:0]                    core_req_i,
    output logic [NB_CORES-1:0]                    core_gnt_o,
    input  logic [NB_CORES*CORE_TAG_WIDTH-1:0]     core_tag_i,
    input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0] core_operands_i,
    input  logic [NB_CORES*OPCODE_WIDTH-1:0]       core_op_i,
    input  logic [NB_CORES*FLAGS_IN_WIDTH-1:0]     core_flags_i,
    output logic [NB_CORES-1:0]                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  core_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]             core_rflags_o,
    output logic [CORE_TAG_WIDTH-1:0]              core_rtag_o,
    output logic                                   fpu_req_o,
    input  logic                                   fpu_gnt_i,
    output logic [FPU_ID_WIDTH-1:0]                fpu_ID_o,
    output logic [NB_ARGS*DATA_WIDTH-1:0]          fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                fpu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]              fpu_flags_o,
    input  logic                                   fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  fpu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]             fpu_rflags_i,
    input  logic [FPU_ID_WIDTH-1:0]                fpu_rID_i,
    output logic [31:0]                            perf_grant_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NB_CORES);
    localparam int unsigned OPS_W = NB_ARGS * DATA_WIDTH;

    logic [IDX_W-1:0]    r_rr_ptr;
    logic [3:0]          r_out_cnt;
    logic [NB_CORES-1:0] r_rvalid;
    logic [DATA_WIDTH-1:0]      r_rdata;
    logic [FLAGS_OUT_WIDTH-1:0] r_rflags;
    logic [CORE_TAG_WIDTH-1:0]  r_rtag;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic                w_can_issue;
    logic                w_issue;
    logic [NB_CORES-1:0] w_gnt;
    logic [IDX_W-1:0]    w_rsp_idx;
    logic                w_rsp_ok;
    logic [IDX_W-1:0]    w_rr_next;

    // First requester at or after r_rr_ptr, wrapping modulo NB_CORES.
    always_comb begin
        int unsigned k;
        k        = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            k = 32'(r_rr_ptr) + i;
            if (k >= NB_CORES) k = k - NB_CORES;
            if (!w_found && core_req_i[k]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(k);
            end
        end
    end

    // A response arriving this cycle frees its credit for a same-cycle issue.
    assign w_can_issue = (r_out_cnt < 4'(MAX_OUTSTANDING)) || fpu_rvalid_i;
    assign fpu_req_o   = !rst && w_found && w_can_issue;
    assign w_issue     = fpu_req_o && fpu_gnt_i;

    always_comb begin
        w_gnt = '0;
        if (w_issue) w_gnt[w_winner] = 1'b1;
    end
    assign core_gnt_o = w_gnt;

    assign fpu_ID_o       = {w_winner, core_tag_i[32'(w_winner)*CORE_TAG_WIDTH +: CORE_TAG_WIDTH]};
    assign fpu_operands_o = core_operands_i[32'(w_winner)*OPS_W +: OPS_W];
    assign fpu_op_o       = core_op_i[32'(w_winner)*OPCODE_WIDTH +: OPCODE_WIDTH];
    assign fpu_flags_o    = core_flags_i[32'(w_winner)*FLAGS_IN_WIDTH +: FLAGS_IN_WIDTH];

    assign w_rr_next = (32'(w_winner) == NB_CORES - 1) ? '0 : w_winner + IDX_W'(1);
    assign w_rsp_idx = fpu_rID_i[FPU_ID_WIDTH-1:CORE_TAG_WIDTH];
    assign w_rsp_ok  = 32'(w_rsp_idx) < NB_CORES;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_issue) r_rr_ptr <= w_rr_next;
            if (w_issue && !fpu_rvalid_i) begin
                r_out_cnt <= r_out_cnt + 4'd1;
            end else if (fpu_rvalid_i && !w_issue && r_out_cnt != 4'd0) begin
                r_out_cnt <= r_out_cnt - 4'd1;
            end
        end
    end

    // Registered response stage: one-cycle pulse to the core encoded in the returned ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_rflags <= '0;
            r_rtag   <= '0;
        end else begin
            r_rvalid <= '0;
            if (fpu_rvalid_i) begin
                if (w_rsp_ok) r_rvalid[w_rsp_idx] <= 1'b1;
                r_rdata  <= fpu_rdata_i;
                r_rflags <= fpu_rflags_i;
                r_rtag   <= fpu_rID_i[CORE_TAG_WIDTH-1:0];
            end
        end
    end

    assign core_rvalid_o = r_rvalid;
    assign core_rdata_o  = r_rdata;
    assign core_rflags_o = r_rflags;
    assign core_rtag_o   = r_rtag;

`ifdef FPU_ARB_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_perf_cnt <= '0;
        else if (w_issue) r_perf_cnt <= r_perf_cnt + 32'd1;
    end
    assign perf_grant_cnt_o = r_perf_cnt;
`else
    assign perf_grant_cnt_o = '0;
`endif

    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (rst)
        !(fpu_rvalid_i && !w_issue && r_out_cnt == 4'd0))
        else $error("response with no outstanding operation");

    a_rsp_idx_range: assert property (@(posedge clk) disable iff (rst)
        !(fpu_rvalid_i && !w_rsp_ok))
        else $error("response core index out of range");

    a_credit_limit: assert property (@(posedge clk) disable iff (rst)
        r_out_cnt <= 4'(MAX_OUTSTANDING))
        else $error("outstanding count above limit");

endmodule

// File: tb/tb_fpu_apu_arbiter.sv
// Directed self-checking bench for fpu_apu_arbiter (default parameters).
module tb_fpu_apu_arbiter;

    localparam int unsigned NC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   core_req_i;
    logic [3:0]   core_gnt_o;
    logic [7:0]   core_tag_i;
    logic [255:0] core_operands_i;
    logic [23:0]  core_op_i;
    logic [59:0]  core_flags_i;
    logic [3:0]   core_rvalid_o;
    logic [31:0]  core_rdata_o;
    logic [4:0]   core_rflags_o;
    logic [1:0]   core_rtag_o;
    logic         fpu_req_o;
    logic         fpu_gnt_i;
    logic [3:0]   fpu_ID_o;
    logic [63:0]  fpu_operands_o;
    logic [5:0]   fpu_op_o;
    logic [14:0]  fpu_flags_o;
    logic         fpu_rvalid_i;
    logic [31:0]  fpu_rdata_i;
    logic [4:0]   fpu_rflags_i;
    logic [3:0]   fpu_rID_i;
    logic [31:0]  perf_grant_cnt_o;

    int total = 0;
    int bad   = 0;

    fpu_apu_arbiter dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_tag_i(core_tag_i),
        .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .core_rflags_o(core_rflags_o), .core_rtag_o(core_rtag_o),
        .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i), .fpu_ID_o(fpu_ID_o),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
        .fpu_rvalid_i(fpu_rvalid_i), .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i),
        .fpu_rID_i(fpu_rID_i), .perf_grant_cnt_o(perf_grant_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core k: operand j = 0xA000_0k0j, opcode k+5, flags 3k+1, tag k.
    function automatic logic [63:0] ops_of(input int k);
        logic [31:0] w1, w0;
        w0 = 32'hA000_0000 | 32'(k << 8);
        w1 = w0 | 32'd1;
        return {w1, w0};
    endfunction

    function automatic logic [3:0] onehot(input int k);
        logic [3:0] v;
        v = 4'b0001 << k;
        return v;
    endfunction

    int exp_perf;

    initial begin
        for (int k = 0; k < int'(NC); k++) begin
            core_operands_i[k*64 +: 64] = ops_of(k);
            core_op_i[k*6 +: 6]         = 6'(k + 5);
            core_flags_i[k*15 +: 15]    = 15'(k * 3 + 1);
            core_tag_i[k*2 +: 2]        = 2'(k);
        end
        rst = 1'b1; core_req_i = '0; fpu_gnt_i = 1'b1;
        fpu_rvalid_i = 1'b0; fpu_rdata_i = '0; fpu_rflags_i = '0; fpu_rID_i = '0;
        exp_perf = 0;
        #1;
        check("reset_rvalid", 64'(core_rvalid_o), 64'h0);
        check("reset_rdata", 64'(core_rdata_o), 64'h0);
        check("reset_perf", 64'(perf_grant_cnt_o), 64'h0);
        tick(); tick();
        rst = 1'b0;

        // All cores requesting, responses three cycles after issue.
        for (int c = 0; c <= 13; c++) begin
            tick();
            if (c >= 4) begin
                check("t1_rvalid", 64'(core_rvalid_o), 64'(onehot((c - 4) % 4)));
                check("t1_rdata", 64'(core_rdata_o), 64'(32'h0000_C000 + 32'(c - 1)));
                check("t1_rtag", 64'(core_rtag_o), 64'((c - 4) % 4));
            end
            core_req_i   = (c < 10) ? 4'hF : 4'h0;
            fpu_rvalid_i = (c >= 3 && c <= 12);
            fpu_rID_i    = {2'((c - 3) % 4), 2'((c - 3) % 4)};
            fpu_rdata_i  = 32'h0000_C000 + 32'(c);
            #1;
            check("t1_gnt", 64'(core_gnt_o), (c < 10) ? 64'(onehot(c % 4)) : 64'h0);
            if (c < 10) begin
                check("t1_id", 64'(fpu_ID_o), 64'({2'(c % 4), 2'(c % 4)}));
                check("t1_ops", fpu_operands_o, ops_of(c % 4));
                check("t1_op", 64'(fpu_op_o), 64'(c % 4 + 5));
                check("t1_flags", 64'(fpu_flags_o), 64'((c % 4) * 3 + 1));
            end
        end
        tick();
        fpu_rvalid_i = 1'b0; core_req_i = '0;
`ifdef FPU_ARB_PERF_CNT_EN
        exp_perf = 10;
`endif
        check("t1_perf", 64'(perf_grant_cnt_o), 64'(exp_perf));

        // rr_ptr is 2: cores 1 and 3 request, core 3 wins first.
        core_req_i = 4'b1010;
        #1;
        check("t2_gnt3", 64'(core_gnt_o), 64'h8);
        check("t2_id3", 64'(fpu_ID_o), 64'h0F);
        tick();
        core_req_i = 4'b0010;
        #1;
        check("t2_gnt1", 64'(core_gnt_o), 64'h2);
        tick();

        // Two outstanding now; two more issues reach the limit of 4.
        core_req_i = 4'hF;
        #1;
        check("t3_gnt2", 64'(core_gnt_o), 64'h4);
        tick(); #1;
        check("t3_gnt3", 64'(core_gnt_o), 64'h8);
        tick(); #1;
        check("t3_req_blocked", 64'(fpu_req_o), 64'h0);
        check("t3_gnt_blocked", 64'(core_gnt_o), 64'h0);
        tick();
        fpu_rvalid_i = 1'b1; fpu_rID_i = {2'd2, 2'b10};
        fpu_rdata_i = 32'h3F80_0000; fpu_rflags_i = 5'h11;
        #1;
        check("t3_req_freed", 64'(fpu_req_o), 64'h1);
        check("t3_gnt0", 64'(core_gnt_o), 64'h1);
        tick();
        fpu_rvalid_i = 1'b0;
        check("t4_rvalid", 64'(core_rvalid_o), 64'h4);
        check("t4_rdata", 64'(core_rdata_o), 64'h3F80_0000);
        check("t4_rtag", 64'(core_rtag_o), 64'h2);
        check("t4_rflags", 64'(core_rflags_o), 64'h11);
        #1;
        check("t3_still_full", 64'(fpu_req_o), 64'h0);
        tick();
        check("t4_pulse_end", 64'(core_rvalid_o), 64'h0);
        check("t4_hold", 64'(core_rdata_o), 64'h3F80_0000);
`ifdef FPU_ARB_PERF_CNT_EN
        exp_perf = 15;
`endif
        check("t5_perf_pre", 64'(perf_grant_cnt_o), 64'(exp_perf));

        // Retire one (out_cnt 3), then reset with a response in flight.
        core_req_i = '0;
        fpu_rvalid_i = 1'b1; fpu_rID_i = {2'd1, 2'b01}; fpu_rdata_i = 32'h1234_5678;
        tick();
        check("t5_rvalid_pre", 64'(core_rvalid_o), 64'h2);
        core_req_i = 4'hF; fpu_rID_i = {2'd3, 2'b11};
        rst = 1'b1;
        #1;
        check("t5_rst_rvalid", 64'(core_rvalid_o), 64'h0);
        check("t5_rst_rdata", 64'(core_rdata_o), 64'h0);
        check("t5_rst_rtag", 64'(core_rtag_o), 64'h0);
        check("t5_rst_req", 64'(fpu_req_o), 64'h0);
        check("t5_rst_gnt", 64'(core_gnt_o), 64'h0);
        check("t5_rst_perf", 64'(perf_grant_cnt_o), 64'h0);
        tick();
        fpu_rvalid_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("t5_first_gnt", 64'(core_gnt_o), 64'h1);
        tick();
        core_req_i = '0;
`ifdef FPU_ARB_PERF_CNT_EN
        exp_perf = 1;
`endif
        check("t5_perf_post", 64'(perf_grant_cnt_o), 64'(exp_perf));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
